debounce: RTL and testbench



---
 rtl/debounce_pkg.sv | 13 +
 rtl/debounce_if.sv | 17 +
 rtl/sync_2ff.sv | 32 +++
 rtl/debounce.sv | 63 ++++++
 tb/tb_debounce.sv | 126 ++++++++++++
 5 files changed

// File: rtl/debounce_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | debounce_pkg                                                         |
// | Shared constants for the push-button debouncer.                      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package debounce_pkg;

  localparam int DEBOUNCE_CNT_DEFAULT = 21;
  localparam int SYNC_STAGES          = 2;

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/debounce_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | debounce_if                                                          |
// | Button-level / press-pulse bundle between board pins and the         |
// | command-select logic.                                                |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface debounce_if;

  logic btn;
  logic raise;

  modport master (output btn, input  raise);
  modport slave  (input  btn, output raise);

endinterface : debounce_if
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_2ff                                                             |
// | Plain flop-chain synchronizer, async active-low reset to 0.          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sync_2ff
  import debounce_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic d,
  output logic      q
);

  logic [STAGES-1:0] r_sync;

  // Pure shift: nothing may sit between the metastability flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  assign q = r_sync[STAGES-1];

endmodule : sync_2ff
`default_nettype wire

// File: rtl/debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | debounce                                                             |
// | Push-button debouncer; one-clock raise pulse per accepted press.     |
// | Build option: DEBOUNCE_ACTIVE_LOW_EN (btn = 0 means pressed).        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module debounce
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEFAULT
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic btn,
  output logic      raise
);

  logic                    w_btn_pol;
  logic                    w_sync_q;
  logic                    r_state;
  logic                    r_raise;
  logic [DEBOUNCE_CNT-1:0] r_cnt;

`ifdef DEBOUNCE_ACTIVE_LOW_EN
  assign w_btn_pol = ~btn;
`else
  assign w_btn_pol = btn;
`endif

  sync_2ff #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (w_btn_pol),
    .q   (w_sync_q)
  );

  // Count consecutive mismatch clocks; any agreeing sample restarts the count,
  // and the all-ones clock is the one that accepts the new level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_state <= 1'b0;
      r_raise <= 1'b0;
    end else if (w_sync_q == r_state) begin
      r_cnt   <= '0;
      r_raise <= 1'b0;
    end else if (!(&r_cnt)) begin
      r_cnt   <= r_cnt + 1'b1;
      r_raise <= 1'b0;
    end else begin
      r_state <= w_sync_q;
      r_cnt   <= '0;
      r_raise <= w_sync_q;
    end
  end

  assign raise = r_raise;

endmodule : debounce
`default_nettype wire

// File: tb/tb_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_debounce                                                          |
// | Directed self-checking bench for debounce with DEBOUNCE_CNT = 4.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_debounce;

`ifdef DEBOUNCE_ACTIVE_LOW_EN
  localparam logic c_press = 1'b0;
`else
  localparam logic c_press = 1'b1;
`endif
  localparam logic c_rel = ~c_press;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  debounce_if bif ();

  debounce #(
    .DEBOUNCE_CNT (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .btn   (bif.btn),
    .raise (bif.raise)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance n clocks; raise must be high only after the pulse_at-th one (0 = never).
  task automatic run(input int n, input int pulse_at, input string tag);
    for (int i = 1; i <= n; i++) begin
      tick();
      check($sformatf("%s_raise@%0d", tag, i), bif.raise, (i == pulse_at));
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    rst     = 1'b0;
    bif.btn = c_rel;

    // Reset state
    repeat (3) tick();
    check("rst_raise", bif.raise, 1'b0);
    check("rst_state", dut.r_state, 1'b0);
    rst = 1'b1;
    run(5, 0, "idle");

    // Clean press: pulse right after edge k+17, i.e. 18th tick
    bif.btn = c_press;
    run(20, 18, "press1");
    run(20, 0, "hold1");
    check("press1_state", dut.r_state, 1'b1);

    // Release gives no pulse, re-press gives one more
    bif.btn = c_rel;
    run(40, 0, "release1");
    check("release1_state", dut.r_state, 1'b0);
    bif.btn = c_press;
    run(20, 18, "press2");
    check("press2_state", dut.r_state, 1'b1);
    bif.btn = c_rel;
    run(40, 0, "release2");
    check("release2_state", dut.r_state, 1'b0);

    // Bounce every 5 clocks never reaches 16 consecutive mismatches
    for (int s = 0; s < 20; s++) begin
      bif.btn = (s % 2 == 0) ? c_press : c_rel;
      run(5, 0, $sformatf("bounce%0d", s));
    end
    bif.btn = c_rel;
    run(30, 0, "bounce_settle");
    check("bounce_state", dut.r_state, 1'b0);

    // Near-threshold glitch: 15 mismatches, one agreeing sample, then restart
    bif.btn = c_press;
    run(15, 0, "glitch_a");
    bif.btn = c_rel;
    run(1, 0, "glitch_b");
    bif.btn = c_press;
    run(24, 18, "glitch_c");
    check("glitch_state", dut.r_state, 1'b1);
    bif.btn = c_rel;
    run(40, 0, "release3");
    check("release3_state", dut.r_state, 1'b0);

    // Reset mid-count (counter at 10), then a fresh full-latency press
    bif.btn = c_press;
    run(12, 0, "midcnt");
    rst = 1'b0;
    #1;
    check("midrst_raise", bif.raise, 1'b0);
    check("midrst_cnt0", (dut.r_cnt == 4'd0), 1'b1);
    run(3, 0, "inrst");
    check("inrst_state", dut.r_state, 1'b0);
    rst = 1'b1;
    run(30, 18, "postrst");
    check("postrst_state", dut.r_state, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_debounce
`default_nettype wire
